// File: rtl/rram_array_ctrl.sv
// rram_array_ctrl: sequencer for the control side of a 2x2 RRAM cell array.
// It drives the wordline, sourceline and bitline enables and the SET-level
// select. SET, RESET and COMPUTE run as timed SETUP/PULSE/RECOVER sequences.
// In COMPUTE, the digitised sum bits are sampled during the tail of PULSE and
// majority-voted into one result per command.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready      command handshake
//   i_cmd_op                     00=SET 01=RESET 10=COMPUTE 11=reserved
//   i_cmd_row, i_cmd_col         wordline mask / column mask
//   o_dwl, o_dsl, o_dbl          wordline / sourceline / bitline enables
//   o_dset                       bitline drives the SET level when 1
//   i_sum_bit                    comparator outputs of the sum nodes
//   o_res_valid/i_res_ready      result handshake
//   o_res_data, o_res_err        voted sum bits, reserved-op flag
//   o_busy                       high whenever not idle
module rram_array_ctrl #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned SAMPLES   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [1:0] i_cmd_row,
  input  logic [1:0] i_cmd_col,
  output logic [1:0] o_dwl,
  output logic [1:0] o_dsl,
  output logic [1:0] o_dbl,
  output logic       o_dset,
  input  logic [1:0] i_sum_bit,
  output logic       o_res_valid,
  input  logic       i_res_ready,
  output logic [1:0] o_res_data,
  output logic       o_res_err,
  output logic       o_busy
);

  localparam int unsigned MaxCyc = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned CycW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned CntW   = $clog2(SAMPLES + 1);

  localparam logic [CycW-1:0] SetupLast = CycW'(SETUP_CYC - 1);
  localparam logic [CycW-1:0] PulseLast = CycW'(PULSE_CYC - 1);
  localparam logic [CycW-1:0] SampFirst = CycW'(PULSE_CYC - SAMPLES);
  localparam logic [CntW-1:0] Half      = CntW'(SAMPLES / 2);

  localparam logic [1:0] OpSet     = 2'b00;
  localparam logic [1:0] OpReset   = 2'b01;
  localparam logic [1:0] OpCompute = 2'b10;
  localparam logic [1:0] OpRsvd    = 2'b11;

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StRecover, StResp} state_e;

  state_e          r_state;
  logic [CycW-1:0] r_cyc;
  logic [1:0]      r_op;
  logic [1:0]      r_row;
  logic [1:0]      r_col;
  logic [CntW-1:0] r_cnt [2];
  logic [1:0]      r_dwl, r_dsl, r_dbl;
  logic            r_dset;
  logic            r_cmd_ready;
  logic            r_busy;
  logic            r_res_valid;
  logic [1:0]      r_res_data;
  logic            r_res_err;

  state_e          w_state_nxt;
  logic [CycW-1:0] w_cyc_nxt;
  logic            w_accept;
  logic            w_sample;
  logic [1:0]      w_dwl_nxt, w_dsl_nxt, w_dbl_nxt;
  logic            w_dset_nxt;
  logic [1:0]      w_res_data_nxt;
  logic            w_res_err_nxt;

  assign w_accept = i_cmd_valid && r_cmd_ready;
  // Sample during the last SAMPLES cycles of PULSE, at the edge ending each cycle.
  assign w_sample = (r_state == StPulse) && (r_cyc >= SampFirst) && (r_op == OpCompute);

  // State register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cyc       <= '0;
      r_op        <= OpSet;
      r_row       <= '0;
      r_col       <= '0;
      r_cnt[0]    <= '0;
      r_cnt[1]    <= '0;
      r_dwl       <= '0;
      r_dsl       <= '0;
      r_dbl       <= '0;
      r_dset      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cyc       <= w_cyc_nxt;
      r_dwl       <= w_dwl_nxt;
      r_dsl       <= w_dsl_nxt;
      r_dbl       <= w_dbl_nxt;
      r_dset      <= w_dset_nxt;
      r_cmd_ready <= (w_state_nxt == StIdle);
      r_busy      <= (w_state_nxt != StIdle);
      r_res_valid <= (w_state_nxt == StResp);
      r_res_data  <= w_res_data_nxt;
      r_res_err   <= w_res_err_nxt;
      if (w_accept) begin
        r_op     <= i_cmd_op;
        r_row    <= i_cmd_row;
        r_col    <= i_cmd_col;
        r_cnt[0] <= '0;
        r_cnt[1] <= '0;
      end else if (w_sample) begin
        r_cnt[0] <= r_cnt[0] + CntW'(i_sum_bit[0]);
        r_cnt[1] <= r_cnt[1] + CntW'(i_sum_bit[1]);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cyc_nxt   = '0;
          w_state_nxt = (i_cmd_op == OpRsvd) ? StResp : StSetup;
        end
      end
      StSetup: begin
        if (r_cyc == SetupLast) begin
          w_state_nxt = StPulse;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CycW'(1);
        end
      end
      StPulse: begin
        if (r_cyc == PulseLast) begin
          w_state_nxt = StRecover;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + CycW'(1);
        end
      end
      StRecover: w_state_nxt = StResp;
      StResp:    if (i_res_ready) w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  // Output logic: values computed for the state being entered, then registered.
  always_comb begin
    w_dwl_nxt      = '0;
    w_dsl_nxt      = '0;
    w_dbl_nxt      = '0;
    w_dset_nxt     = 1'b0;
    w_res_data_nxt = r_res_data;
    w_res_err_nxt  = r_res_err;
    unique case (w_state_nxt)
      StSetup: w_dwl_nxt = w_accept ? i_cmd_row : r_row;
      StPulse: begin
        w_dwl_nxt = r_row;
        unique case (r_op)
          OpSet: begin
            w_dbl_nxt  = r_col;
            w_dset_nxt = 1'b1;
          end
          OpReset:   w_dsl_nxt = r_col;
          OpCompute: w_dbl_nxt = r_col;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (w_accept) begin
      w_res_data_nxt = '0;
      w_res_err_nxt  = (i_cmd_op == OpRsvd);
    end else if (r_state == StRecover && r_op == OpCompute) begin
      w_res_data_nxt = {(r_cnt[1] > Half), (r_cnt[0] > Half)};
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_dwl       = r_dwl;
  assign o_dsl       = r_dsl;
  assign o_dbl       = r_dbl;
  assign o_dset      = r_dset;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_err   = r_res_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_rram_array_ctrl.sv
// tb_rram_array_ctrl: self-checking bench for rram_array_ctrl. Expected
// results are queued when a command is issued and compared when the
// controller hands its result over.
module tb_rram_array_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00, cmd_row = 2'b00, cmd_col = 2'b00;
  logic [1:0] dwl, dsl, dbl;
  logic       dset;
  logic [1:0] sum_bit = 2'b00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_data;
  logic       res_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q [$];        // {err, data}
  logic [1:0] sum_seq [0:31];   // sum_bit applied in cycle k after accept
  logic [6:0] tr_lines [0:31];  // {dwl, dsl, dbl, dset} observed in cycle k
  logic       tr_rdy [0:31];
  int         lat;
  logic [1:0] got_data;
  logic       got_err;
  logic       stable;
  logic       post_rv, post_rdy;

  always #5 clk = ~clk;

  rram_array_ctrl #(.SETUP_CYC(2), .PULSE_CYC(4), .SAMPLES(3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_row   (cmd_row),
    .i_cmd_col   (cmd_col),
    .o_dwl       (dwl),
    .o_dsl       (dsl),
    .o_dbl       (dbl),
    .o_dset      (dset),
    .i_sum_bit   (sum_bit),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_err   (res_err),
    .o_busy      (busy)
  );

  // Expected line drive in cycle k after accept.
  function automatic logic [6:0] exp_lines(input logic [1:0] op, row, col, input int k);
    if (op == 2'b11 || k < 1) return 7'd0;
    if (k <= SETUP_CYC) return {row, 4'b0000, 1'b0};
    if (k <= SETUP_CYC + PULSE_CYC) begin
      case (op)
        2'b00:   return {row, 2'b00, col, 1'b1};
        2'b01:   return {row, col, 2'b00, 1'b0};
        default: return {row, 2'b00, col, 1'b0};
      endcase
    end
    return 7'd0;
  endfunction

  // Fill the sum_bit schedule: 'other' everywhere, a/b/c in the last three PULSE cycles.
  task automatic set_seq(input logic [1:0] a, b, c, other);
    for (int k = 0; k < 32; k++) sum_seq[k] = other;
    sum_seq[4] = a;
    sum_seq[5] = b;
    sum_seq[6] = c;
  endtask

  // Issue one command, trace lines per cycle, complete the result handshake
  // after holding res_ready low for 'hold' cycles. Bounded to 31 cycles.
  task automatic run_cmd(input logic [1:0] op, row, col, input int hold, input bit pend);
    int held;
    held = 0;
    lat = -1;
    stable = 1'b1;
    post_rv = 1'bx;
    post_rdy = 1'bx;
    got_data = 2'bxx;
    got_err = 1'bx;
    for (int k = 0; k < 32; k++) begin
      tr_lines[k] = 7'bx;
      tr_rdy[k] = 1'bx;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_row = row;
    cmd_col = col;
    sum_bit = sum_seq[0];
    @(posedge clk); #1;
    cmd_valid = pend;
    cmd_op = 2'b11;
    cmd_row = ~row;
    cmd_col = ~col;
    for (int k = 1; k < 32; k++) begin
      sum_bit = sum_seq[k];
      @(negedge clk);
      tr_lines[k] = {dwl, dsl, dbl, dset};
      tr_rdy[k] = cmd_ready;
      if (res_valid) begin
        if (lat < 0) begin
          lat = k;
          got_data = res_data;
          got_err = res_err;
        end else if ({res_err, res_data} !== {got_err, got_data}) begin
          stable = 1'b0;
        end
        if (held >= hold) begin
          res_ready = 1'b1;
          cmd_valid = 1'b0;
          @(posedge clk); #1;
          res_ready = 1'b0;
          post_rv = res_valid;
          post_rdy = cmd_ready;
          break;
        end
        held++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    sum_bit = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dwl, dsl, dbl, dset} !== 7'd0) begin
      errors++;
      $display("FAIL reset_lines: got %b want 0000000", {dwl, dsl, dbl, dset});
    end
    checks++;
    if ({cmd_ready, busy, res_valid, res_data, res_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_status: got %b want 100000", {cmd_ready, busy, res_valid, res_data, res_err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_set();
    logic [2:0] exp;
    set_seq(2'b11, 2'b11, 2'b11, 2'b11);
    exp_q.push_back({1'b0, 2'b00});
    run_cmd(2'b00, 2'b10, 2'b01, 0, 1'b0);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL set_latency: got %0d want 8", lat); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (tr_lines[k] !== exp_lines(2'b00, 2'b10, 2'b01, k)) begin
        errors++;
        $display("FAIL set_lines[%0d]: got %b want %b", k, tr_lines[k],
                 exp_lines(2'b00, 2'b10, 2'b01, k));
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL set_result: got %b want %b", {got_err, got_data}, exp);
    end
    checks++;
    if ({post_rv, post_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL set_post_handshake: got %b want 01", {post_rv, post_rdy});
    end
  endtask

  task automatic test_reset_op();
    logic [2:0] exp;
    set_seq(2'b00, 2'b00, 2'b00, 2'b00);
    exp_q.push_back({1'b0, 2'b00});
    run_cmd(2'b01, 2'b11, 2'b10, 0, 1'b0);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL rst_op_latency: got %0d want 8", lat); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (tr_lines[k] !== exp_lines(2'b01, 2'b11, 2'b10, k)) begin
        errors++;
        $display("FAIL rst_op_lines[%0d]: got %b want %b", k, tr_lines[k],
                 exp_lines(2'b01, 2'b11, 2'b10, k));
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL rst_op_result: got %b want %b", {got_err, got_data}, exp);
    end
  endtask

  task automatic test_compute();
    logic [2:0] exp;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin set_seq(2'b10, 2'b10, 2'b10, 2'b00); exp_q.push_back(3'b010); end
        1: begin
          set_seq(2'b01, 2'b00, 2'b01, 2'b00);
          sum_seq[7] = 2'b11;  // RECOVER cycle, outside the window
          exp_q.push_back(3'b001);
        end
        2: begin set_seq(2'b01, 2'b00, 2'b00, 2'b00); exp_q.push_back(3'b000); end
        default: begin
          set_seq(2'b00, 2'b00, 2'b00, 2'b00);
          sum_seq[3] = 2'b11;  // first PULSE cycle only
          exp_q.push_back(3'b000);
        end
      endcase
      run_cmd(2'b10, 2'b11, 2'b11, 0, 1'b0);
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL compute%0d_latency: got %0d want 8", p, lat); end
      for (int k = 1; k <= 8; k++) begin
        checks++;
        if (tr_lines[k] !== exp_lines(2'b10, 2'b11, 2'b11, k)) begin
          errors++;
          $display("FAIL compute%0d_lines[%0d]: got %b want %b", p, k, tr_lines[k],
                   exp_lines(2'b10, 2'b11, 2'b11, k));
        end
      end
      exp = exp_q.pop_front();
      checks++;
      if ({got_err, got_data} !== exp) begin
        errors++;
        $display("FAIL compute%0d_result: got %b want %b", p, {got_err, got_data}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    set_seq(2'b11, 2'b11, 2'b11, 2'b00);
    exp_q.push_back({1'b0, 2'b11});
    run_cmd(2'b10, 2'b01, 2'b10, 5, 1'b1);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL hold_latency: got %0d want 8", lat); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b want 1", stable); end
    for (int k = 8; k <= 13; k++) begin
      checks++;
      if (tr_rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL hold_cmd_ready[%0d]: got %b want 0", k, tr_rdy[k]);
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL hold_result: got %b want %b", {got_err, got_data}, exp);
    end
    checks++;
    if ({post_rv, post_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL hold_post_handshake: got %b want 01", {post_rv, post_rdy});
    end
    // Next command issued immediately: accepted in the cycle after the handshake.
    exp_q.push_back({1'b1, 2'b00});
    run_cmd(2'b11, 2'b01, 2'b01, 0, 1'b0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL b2b_latency: got %0d want 1", lat); end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL b2b_result: got %b want %b", {got_err, got_data}, exp);
    end
  endtask

  task automatic test_reserved();
    logic [2:0] exp;
    set_seq(2'b11, 2'b11, 2'b11, 2'b11);
    exp_q.push_back({1'b1, 2'b00});
    run_cmd(2'b11, 2'b11, 2'b11, 2, 1'b0);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (tr_lines[k] !== 7'd0) begin
        errors++;
        $display("FAIL rsvd_lines[%0d]: got %b want 0000000", k, tr_lines[k]);
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL rsvd_result: got %b want %b", {got_err, got_data}, exp);
    end
  endtask

  task automatic test_abort();
    logic [2:0] exp;
    int seen;
    set_seq(2'b00, 2'b00, 2'b00, 2'b00);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_row = 2'b11;
    cmd_col = 2'b11;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dwl, dbl, dset} !== 5'b11111) begin
      errors++;
      $display("FAIL abort_in_pulse: got %b want 11111", {dwl, dbl, dset});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dwl, dsl, dbl, dset, busy, cmd_ready} !== 9'b000000001) begin
      errors++;
      $display("FAIL abort_lines: got %b want 000000001", {dwl, dsl, dbl, dset, busy, cmd_ready});
    end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_result: got %0d want 0", seen); end
    @(posedge clk); #1;
    set_seq(2'b01, 2'b01, 2'b11, 2'b00);
    exp_q.push_back({1'b0, 2'b01});
    run_cmd(2'b10, 2'b10, 2'b01, 0, 1'b0);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL abort_next_latency: got %0d want 8", lat); end
    exp = exp_q.pop_front();
    checks++;
    if ({got_err, got_data} !== exp) begin
      errors++;
      $display("FAIL abort_next_result: got %b want %b", {got_err, got_data}, exp);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_reset_op();
    test_compute();
    test_back_to_back();
    test_reserved();
    test_abort();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rram_array_ctrl.md
Name: rram_array_ctrl

Overview:
- Digital sequencer driving the control side of the 2x2 RRAM cell model: wordline, sourceline and bitline enables plus the SET-level select.
- Reads back the digitised sigmoid outputs.
- Executes SET, RESET and COMPUTE operations as timed pulse sequences.
- Majority-votes the sampled sum bits and returns one result per command over a valid/ready handshake.
- Sits between the mapping/scheduling logic and the analog cell array.

Parameters:
- SETUP_CYC, 2, cycles wordlines are driven before the pulse phase (min 1)
- PULSE_CYC, 4, cycles of the SET/RESET/read pulse phase (min 1)
- SAMPLES, 3, number of final PULSE cycles in which sum_bit is sampled during COMPUTE; odd; 1 <= SAMPLES <= PULSE_CYC

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00=SET, 01=RESET, 10=COMPUTE, 11=reserved
- cmd_row  input  2  wordline mask (COMPUTE: input activation vector)
- cmd_col  input  2  column mask
- Dwl  output  2  wordline enables
- Dsl  output  2  sourceline enables
- Dbl  output  2  bitline enables
- Dset  output  1  bitline drives 2*vdd when 1
- sum_bit  input  2  comparator outputs of the sum nodes (1 when sum > 0.5)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  2  majority-voted sum bits (COMPUTE); 0 for other ops
- res_err  output  1  reserved op flag
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock, reset and registers:
  - Single clock; all outputs registered.
  - rst sampled at the clk edge. On reset: state=IDLE, Dwl=Dsl=Dbl=0, Dset=0, res_valid=0, res_data=0, res_err=0, busy=0, cmd_ready=1.
  - Reset mid-operation aborts immediately: lines return to 0 at the next edge and any pending result is dropped.
- Command capture:
  - cmd_ready=1 only in IDLE.
  - Accept occurs on an edge where cmd_valid && cmd_ready. op, row and col are latched then; later input changes are ignored.
- States: IDLE -> SETUP -> PULSE -> RECOVER -> RESP -> IDLE.
- SETUP (SETUP_CYC cycles, starting the cycle after accept):
  - Dwl=row, Dsl=0, Dbl=0, Dset=0.
- PULSE (PULSE_CYC cycles):
  - SET: Dwl=row, Dbl=col, Dset=1, Dsl=0.
  - RESET: Dwl=row, Dsl=col, Dbl=0, Dset=0.
  - COMPUTE: Dwl=row, Dbl=col, Dset=0, Dsl=0.
  - COMPUTE sampling: in each of the last SAMPLES PULSE cycles, sum_bit[i] is sampled at the clock edge ending that cycle. A per-bit counter of width clog2(SAMPLES+1) increments when the sample is 1. Counters clear on accept.
  - Dset and Dsl are never both high, and no bit of Dsl and Dbl is high simultaneously.
- RECOVER (1 cycle): all lines 0.
  - res_data[i] = (count[i] > SAMPLES/2) for COMPUTE, else 0.
- RESP:
  - res_valid=1; res_data and res_err held stable until res_ready.
  - The edge with res_valid && res_ready returns to IDLE; res_valid=0 next cycle.
  - res_ready high before res_valid has no effect.
- Reserved op (11):
  - Accepted, then IDLE -> RESP directly; lines stay 0, res_err=1, res_data=0.
- Masks:
  - row=0 or col=0 is legal: the sequence runs with the corresponding lines 0, same timing.
- Latency:
  - Accept to res_valid = SETUP_CYC + PULSE_CYC + 1 + 1 cycles; 8 with defaults.
  - Reserved op: 1 cycle.
  - Back-to-back: the next accept is possible in the cycle after the response handshake.

Test Plan:
- Reset, then SET op=00 row=10 col=01:
  - Dwl=10 for 2 cycles.
  - Then Dwl=10, Dbl=01, Dset=1 for 4 cycles.
  - Then all 0.
  - res_valid 8 cycles after accept, res_data=00, res_err=0.
- RESET op=01 row=11 col=10:
  - Dsl=10 and Dbl=00 throughout PULSE; Dset never 1.
  - res_valid 8 cycles after accept.
- COMPUTE op=10 row=11 col=11:
  - sum_bit=10 in the last 3 PULSE cycles -> res_data=10.
  - Repeat with sum_bit[0] pattern 1,0,1 -> res_data bit0=1.
  - Pattern 1,0,0 -> bit0=0.
  - sum_bit=11 during the first PULSE cycle only -> ignored, res_data=00.
- Hold res_ready=0 for 5 cycles after res_valid:
  - res_valid and res_data stable, cmd_ready=0.
  - New cmd_valid not accepted until after the handshake.
- Reserved op=11:
  - No line ever toggles.
  - res_valid 1 cycle after accept, res_err=1, res_data=00.
- Assert rst during the PULSE of a SET:
  - Next cycle Dwl=Dbl=0, Dset=0, busy=0, cmd_ready=1.
  - No res_valid for the aborted command.
  - A following COMPUTE completes normally.
